aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_slice_counter.sv | 28 ++
 rtl/aes_round_ctrl.sv | 131 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES round-controller types: FSM state enum, key-size mode encodings
// and round counts, plus nr_of() mapping a mode to its final round index.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYGEN = 2'd1,
        ST_ROUNDS = 2'd2,
        ST_DONE   = 2'd3
    } aes_state_e;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: nr_of = NR_192;
            MODE_256: nr_of = NR_256;
            default:  nr_of = NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_slice_counter.sv
// Wrap-around slice counter 0..SLICES-1; wrap flags the last enabled slice
// and the counter returns to 0 on the following edge.
module aes_slice_counter #(
    parameter int SLICES  = 4,
    parameter int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    output logic [SLICE_W-1:0] cnt,
    output logic               wrap
);

    localparam logic [SLICE_W-1:0] LAST = SLICE_W'(SLICES - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr || wrap)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks rounds/slices for a block, with an optional
// decrypt key-schedule pre-pass enabled by defining AES_ROUND_CTRL_DEC_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int SLICES  = 4,
    parameter int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               enc_dec,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic [3:0]         round,
    output logic [SLICE_W-1:0] slice,
    output logic               round_start,
    output logic               round_complete,
    output logic               last_round,
    output logic               key_gen,
    output logic [3:0]         key_round,
    output logic               done,
    output logic               mode_err
);

`ifdef AES_ROUND_CTRL_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    aes_state_e state;
    logic       enc_dec_r;
    logic [1:0] mode_r;
    logic [3:0] round_r;
    logic [3:0] key_round_r;
    logic       busy_r, done_r, mode_err_r, key_gen_r;

    logic       in_rounds, slice_wrap, final_rnd, reject;
    logic [3:0] nr;

    assign nr        = nr_of(mode_r);
    assign in_rounds = (state == ST_ROUNDS);
    assign final_rnd = enc_dec_r ? (round_r == 4'd0) : (round_r == nr);
    // Without the decrypt path a decrypt request is refused exactly like mode 11.
    assign reject    = (mode == MODE_ILL) || (enc_dec && !DEC_EN);

    aes_slice_counter #(.SLICES(SLICES), .SLICE_W(SLICE_W)) u_slice (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!in_rounds),
        .en      (in_rounds),
        .cnt     (slice),
        .wrap    (slice_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            enc_dec_r   <= 1'b0;
            mode_r      <= MODE_128;
            round_r     <= '0;
            key_round_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mode_err_r  <= 1'b0;
            key_gen_r   <= 1'b0;
        end else begin
            mode_err_r <= 1'b0;
            done_r     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (reject) begin
                            mode_err_r <= 1'b1;
                        end else begin
                            mode_r    <= mode;
                            enc_dec_r <= enc_dec;
                            busy_r    <= 1'b1;
                            round_r   <= '0;
                            if (DEC_EN && enc_dec) begin
                                state       <= ST_KEYGEN;
                                key_gen_r   <= 1'b1;
                                key_round_r <= '0;
                            end else begin
                                state <= ST_ROUNDS;
                            end
                        end
                    end
                end
                ST_KEYGEN: begin
                    if (key_round_r == nr) begin
                        state       <= ST_ROUNDS;
                        key_gen_r   <= 1'b0;
                        key_round_r <= '0;
                        round_r     <= nr;
                    end else begin
                        key_round_r <= key_round_r + 4'd1;
                    end
                end
                ST_ROUNDS: begin
                    if (slice_wrap) begin
                        if (final_rnd) begin
                            state   <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            round_r <= '0;
                        end else begin
                            round_r <= enc_dec_r ? round_r - 4'd1 : round_r + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign mode_err       = mode_err_r;
    assign round          = round_r;
    assign key_gen        = key_gen_r;
    assign key_round      = key_round_r;
    assign round_start    = in_rounds && (slice == '0);
    assign round_complete = slice_wrap;
    assign last_round     = in_rounds && final_rnd;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: SLICES=4 instance (a) and SLICES=1 instance (b).
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 0, enc_a = 0;
    logic [1:0] mode_a = 0;
    logic       busy_a, rs_a, rc_a, lr_a, kg_a, done_a, err_a;
    logic [3:0] round_a, kr_a;
    logic [1:0] slice_a;

    logic       start_b = 0, enc_b = 0;
    logic [1:0] mode_b = 0;
    logic       busy_b, rs_b, rc_b, lr_b, kg_b, done_b, err_b;
    logic [3:0] round_b, kr_b;
    logic [0:0] slice_b;

    aes_round_ctrl #(.SLICES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .enc_dec(enc_a), .mode(mode_a),
        .busy(busy_a), .round(round_a), .slice(slice_a), .round_start(rs_a),
        .round_complete(rc_a), .last_round(lr_a), .key_gen(kg_a), .key_round(kr_a),
        .done(done_a), .mode_err(err_a));

    aes_round_ctrl #(.SLICES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .enc_dec(enc_b), .mode(mode_b),
        .busy(busy_b), .round(round_b), .slice(slice_b), .round_start(rs_b),
        .round_complete(rc_b), .last_round(lr_b), .key_gen(kg_b), .key_round(kr_b),
        .done(done_b), .mode_err(err_b));

    int vecs = 0, errs = 0;
    int busy_cnt, done_cyc, rs_cnt, rc_cnt, lr_cnt, kg_cnt, err_cnt, seq_err, max_round, lr_round;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Observes one operation from the first cycle after the start edge until done,
    // comparing each cycle against the expected round/slice/key-step walk.
    task automatic run_op(input int nr, input bit dec, input int sl, input bit use_b);
        int idx, r, er, kc;
        int o_busy, o_round, o_slice, o_rs, o_rc, o_lr, o_kg, o_kr, o_done, o_err;
        busy_cnt = 0; done_cyc = 0; rs_cnt = 0; rc_cnt = 0; lr_cnt = 0; kg_cnt = 0;
        err_cnt = 0; seq_err = 0; max_round = 0; lr_round = -1;
        kc = dec ? nr + 1 : 0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (use_b) begin
                o_busy = busy_b; o_round = round_b; o_slice = slice_b; o_rs = rs_b; o_rc = rc_b;
                o_lr = lr_b; o_kg = kg_b; o_kr = kr_b; o_done = done_b; o_err = err_b;
            end else begin
                o_busy = busy_a; o_round = round_a; o_slice = slice_a; o_rs = rs_a; o_rc = rc_a;
                o_lr = lr_a; o_kg = kg_a; o_kr = kr_a; o_done = done_a; o_err = err_a;
            end
            if (o_done) begin
                done_cyc = cyc;
                if (o_busy) seq_err++;
                break;
            end
            busy_cnt += o_busy; rs_cnt += o_rs; rc_cnt += o_rc; lr_cnt += o_lr;
            kg_cnt += o_kg; err_cnt += o_err;
            if (o_round > max_round) max_round = o_round;
            if (o_lr) lr_round = o_round;
            if (cyc <= kc) begin
                if (!o_kg || o_kr != cyc - 1 || !o_busy || o_rs || o_rc) seq_err++;
            end else begin
                idx = cyc - 1 - kc;
                r = idx / sl;
                if (r > nr) seq_err++;
                else begin
                    er = dec ? nr - r : r;
                    if (o_round != er || o_slice != idx % sl || o_kg || !o_busy) seq_err++;
                    if (o_lr != int'(r == nr)) seq_err++;
                    if (o_rs != int'(idx % sl == 0) || o_rc != int'(idx % sl == sl - 1)) seq_err++;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if ({busy_a, round_a, slice_a, rs_a, rc_a, lr_a, kg_a, kr_a, done_a, err_a} !== '0) begin
            errs++; $display("FAIL reset_outputs_a: got %0h want 0",
                {busy_a, round_a, slice_a, rs_a, rc_a, lr_a, kg_a, kr_a, done_a, err_a});
        end
        vecs++;
        if ({busy_b, round_b, slice_b, rs_b, rc_b, lr_b, kg_b, kr_b, done_b, err_b} !== '0) begin
            errs++; $display("FAIL reset_outputs_b: got %0h want 0",
                {busy_b, round_b, slice_b, rs_b, rc_b, lr_b, kg_b, kr_b, done_b, err_b});
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_enc128;
        start_a = 1; enc_a = 0; mode_a = 2'b00;
        tick();
        start_a = 0;
        run_op(10, 0, 4, 0);
        vecs++; if (busy_cnt !== 44) begin errs++; $display("FAIL enc128_busy: got %0d want 44", busy_cnt); end
        vecs++; if (done_cyc !== 45) begin errs++; $display("FAIL enc128_done_cycle: got %0d want 45", done_cyc); end
        vecs++; if (rs_cnt !== 11) begin errs++; $display("FAIL enc128_round_start: got %0d want 11", rs_cnt); end
        vecs++; if (rc_cnt !== 11) begin errs++; $display("FAIL enc128_round_complete: got %0d want 11", rc_cnt); end
        vecs++; if (lr_cnt !== 4 || lr_round !== 10) begin errs++; $display("FAIL enc128_last_round: got %0d/%0d want 4/10", lr_cnt, lr_round); end
        vecs++; if (seq_err !== 0) begin errs++; $display("FAIL enc128_sequence: got %0d bad cycles want 0", seq_err); end
        tick();
        vecs++; if (done_a !== 0 || busy_a !== 0) begin errs++; $display("FAIL enc128_done_width: got done=%0d busy=%0d want 0/0", done_a, busy_a); end
    endtask

`ifdef AES_ROUND_CTRL_DEC_EN
    task automatic test_dec256;
        start_a = 1; enc_a = 1; mode_a = 2'b10;
        tick();
        start_a = 0; enc_a = 0; mode_a = 2'b00;
        run_op(14, 1, 4, 0);
        vecs++; if (busy_cnt !== 75) begin errs++; $display("FAIL dec256_busy: got %0d want 75", busy_cnt); end
        vecs++; if (done_cyc !== 76) begin errs++; $display("FAIL dec256_done_cycle: got %0d want 76", done_cyc); end
        vecs++; if (kg_cnt !== 15) begin errs++; $display("FAIL dec256_keygen: got %0d want 15", kg_cnt); end
        vecs++; if (lr_cnt !== 4 || lr_round !== 0) begin errs++; $display("FAIL dec256_last_round: got %0d/%0d want 4/0", lr_cnt, lr_round); end
        vecs++; if (seq_err !== 0) begin errs++; $display("FAIL dec256_sequence: got %0d bad cycles want 0", seq_err); end
        tick();
    endtask
`endif

    task automatic test_mode_err;
        start_a = 1; enc_a = 0; mode_a = 2'b11;
        tick();
        start_a = 0; mode_a = 2'b00;
        vecs++; if (err_a !== 1 || busy_a !== 0) begin errs++; $display("FAIL illegal_mode: got err=%0d busy=%0d want 1/0", err_a, busy_a); end
        tick();
        vecs++; if (err_a !== 0 || busy_a !== 0) begin errs++; $display("FAIL illegal_mode_pulse: got err=%0d busy=%0d want 0/0", err_a, busy_a); end
`ifndef AES_ROUND_CTRL_DEC_EN
        start_a = 1; enc_a = 1; mode_a = 2'b00;
        tick();
        start_a = 0; enc_a = 0;
        vecs++; if (err_a !== 1 || busy_a !== 0 || kg_a !== 0) begin errs++; $display("FAIL decrypt_refused: got err=%0d busy=%0d kg=%0d want 1/0/0", err_a, busy_a, kg_a); end
        tick();
        vecs++; if (err_a !== 0 || busy_a !== 0) begin errs++; $display("FAIL decrypt_refused_pulse: got err=%0d busy=%0d want 0/0", err_a, busy_a); end
`endif
    endtask

    task automatic test_back_to_back;
        start_a = 1; enc_a = 0; mode_a = 2'b01;
        tick();
        mode_a = 2'b00;
        run_op(12, 0, 4, 0);
        vecs++; if (max_round !== 12 || busy_cnt !== 52) begin errs++; $display("FAIL held_start_192: got max_round=%0d busy=%0d want 12/52", max_round, busy_cnt); end
        vecs++; if (seq_err !== 0 || err_cnt !== 0) begin errs++; $display("FAIL held_start_sequence: got %0d/%0d want 0/0", seq_err, err_cnt); end
        tick();
        vecs++; if (busy_a !== 0) begin errs++; $display("FAIL b2b_idle: got busy=%0d want 0", busy_a); end
        tick();
        start_a = 0;
        vecs++; if (busy_a !== 1 || round_a !== 0) begin errs++; $display("FAIL b2b_restart: got busy=%0d round=%0d want 1/0", busy_a, round_a); end
        run_op(10, 0, 4, 0);
        vecs++; if (done_cyc !== 45 || seq_err !== 0) begin errs++; $display("FAIL b2b_second_op: got done=%0d err=%0d want 45/0", done_cyc, seq_err); end
        tick();
    endtask

    task automatic test_reset_mid;
        int found = 0, dn = 0;
        start_a = 1; enc_a = 0; mode_a = 2'b00;
        tick();
        start_a = 0;
        for (int i = 0; i < 100; i++) begin
            if (round_a == 5 && slice_a == 2) begin found = 1; break; end
            tick();
        end
        vecs++; if (found !== 1) begin errs++; $display("FAIL reset_mid_reach: got %0d want 1", found); end
        #2 reset_n = 0;
        #1;
        vecs++;
        if ({busy_a, round_a, slice_a, rs_a, rc_a, lr_a, kg_a, kr_a, done_a, err_a} !== '0) begin
            errs++; $display("FAIL reset_mid_async: got %0h want 0",
                {busy_a, round_a, slice_a, rs_a, rc_a, lr_a, kg_a, kr_a, done_a, err_a});
        end
        for (int i = 0; i < 3; i++) begin tick(); dn += done_a + busy_a; end
        vecs++; if (dn !== 0) begin errs++; $display("FAIL reset_mid_no_done: got %0d want 0", dn); end
        reset_n = 1; start_a = 1;
        tick();
        start_a = 0;
        run_op(10, 0, 4, 0);
        vecs++; if (busy_cnt !== 44 || done_cyc !== 45 || seq_err !== 0) begin errs++; $display("FAIL reset_mid_rerun: got busy=%0d done=%0d err=%0d want 44/45/0", busy_cnt, done_cyc, seq_err); end
        tick();
    endtask

    task automatic test_slices1;
        start_b = 1; enc_b = 0; mode_b = 2'b01;
        tick();
        start_b = 0;
        run_op(12, 0, 1, 1);
        vecs++; if (busy_cnt !== 13 || done_cyc !== 14) begin errs++; $display("FAIL slices1_timing: got busy=%0d done=%0d want 13/14", busy_cnt, done_cyc); end
        vecs++; if (rs_cnt !== 13 || rc_cnt !== 13) begin errs++; $display("FAIL slices1_flags: got rs=%0d rc=%0d want 13/13", rs_cnt, rc_cnt); end
        vecs++; if (seq_err !== 0) begin errs++; $display("FAIL slices1_sequence: got %0d want 0", seq_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_enc128();
`ifdef AES_ROUND_CTRL_DEC_EN
        test_dec256();
`endif
        test_mode_err();
        test_back_to_back();
        test_reset_mid();
        test_slices1();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
